// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm minute match with arm/ring/snooze state machine
// Watches MM:SS BCD time, rings for RING_SECONDS ticks, snoozes for SNOOZE_SECONDS ticks.
module alarm_controller #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [15:0] time_bcd,
  input  logic [7:0]  alarm_in,
  input  logic        set_alarm,
  input  logic        arm,
  input  logic        snooze,
  input  logic        dismiss,
  output logic [7:0]  alarm_bcd,
  output logic [1:0]  state,
  output logic        ringing,
  output logic        buzzer,
  output logic        set_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RING_CNT   = CNT_W'(RING_SECONDS);
  localparam logic [CNT_W-1:0] SNOOZE_CNT = CNT_W'(SNOOZE_SECONDS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             buzzer_q, buzzer_d;
  logic [7:0]       alarm_q, alarm_d;
  logic             set_err_q, set_err_d;
  logic             match_q;

  logic match;
  logic trigger;
  logic set_valid;

  assign match     = (time_bcd == {alarm_q, 8'h00});
  // Rising edge of the match gives one trigger per pass through the alarm minute.
  assign trigger   = match && !match_q;
  assign set_valid = set_alarm && (alarm_in[7:4] <= 4'd9) && (alarm_in[3:0] <= 4'd9);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      buzzer_q  <= 1'b0;
      alarm_q   <= 8'h00;
      set_err_q <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buzzer_q  <= buzzer_d;
      alarm_q   <= alarm_d;
      set_err_q <= set_err_d;
      match_q   <= match;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buzzer_d  = buzzer_q;
    alarm_d   = set_valid ? alarm_in : alarm_q;
    set_err_d = set_alarm && !set_valid;

    if (!arm) begin
      state_d = IDLE;
    end else if (set_valid && (state_q == RINGING || state_q == SNOOZE)) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (trigger) begin
            state_d  = RINGING;
            cnt_d    = RING_CNT;
            buzzer_d = 1'b1;
          end
        end
        RINGING: begin
          if (dismiss) begin
            state_d = ARMED;
          end else if (snooze) begin
            state_d = SNOOZE;
            cnt_d   = SNOOZE_CNT;
          end else if (tick) begin
            if (cnt_q == CNT_ONE) begin
              state_d = ARMED;
            end else begin
              cnt_d    = cnt_q - CNT_ONE;
              buzzer_d = ~buzzer_q;
            end
          end
        end
        SNOOZE: begin
          if (dismiss) begin
            state_d = ARMED;
          end else if (tick) begin
            if (cnt_q == CNT_ONE) begin
              state_d  = RINGING;
              cnt_d    = RING_CNT;
              buzzer_d = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_d != RINGING) buzzer_d = 1'b0;
  end

  always_comb begin
    state     = state_q;
    ringing   = (state_q == RINGING);
    buzzer    = buzzer_q && (state_q == RINGING);
    alarm_bcd = alarm_q;
    set_err   = set_err_q;
  end

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - directed self-checking bench for alarm_controller
module tb_alarm_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [15:0] time_bcd;
  logic [7:0]  alarm_in;
  logic        set_alarm;
  logic        arm;
  logic        snooze;
  logic        dismiss;
  logic [7:0]  alarm_bcd;
  logic [1:0]  state;
  logic        ringing;
  logic        buzzer;
  logic        set_err;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_RING = 2'd2, S_SNZ = 2'd3;

  alarm_controller #(
    .RING_SECONDS  (3),
    .SNOOZE_SECONDS(4),
    .CNT_W         (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .time_bcd (time_bcd),
    .alarm_in (alarm_in),
    .set_alarm(set_alarm),
    .arm      (arm),
    .snooze   (snooze),
    .dismiss  (dismiss),
    .alarm_bcd(alarm_bcd),
    .state    (state),
    .ringing  (ringing),
    .buzzer   (buzzer),
    .set_err  (set_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic retrigger();
    time_bcd = 16'h0701;
    cyc();
    time_bcd = 16'h0700;
    cyc();
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; time_bcd = 16'h0000; alarm_in = 8'h00;
    set_alarm = 1'b0; arm = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    cyc();
    cyc();
    chk("rst_state", 16'(state), 16'(S_IDLE));
    chk("rst_ringing", 16'(ringing), 16'd0);
    chk("rst_buzzer", 16'(buzzer), 16'd0);
    chk("rst_set_err", 16'(set_err), 16'd0);
    chk("rst_alarm", 16'(alarm_bcd), 16'h0000);

    reset = 1'b0; time_bcd = 16'h0659; alarm_in = 8'h07; set_alarm = 1'b1; arm = 1'b1;
    cyc();
    set_alarm = 1'b0;
    chk("set_state", 16'(state), 16'(S_ARMED));
    chk("set_alarm", 16'(alarm_bcd), 16'h0007);
    chk("set_no_err", 16'(set_err), 16'd0);

    time_bcd = 16'h0700;
    #1;
    chk("pre_edge_ringing", 16'(ringing), 16'd0);
    cyc();
    chk("trig_ringing", 16'(ringing), 16'd1);
    chk("trig_state", 16'(state), 16'(S_RING));
    chk("trig_buzzer", 16'(buzzer), 16'd1);
    do_tick();
    chk("tick1_buzzer", 16'(buzzer), 16'd0);
    chk("tick1_state", 16'(state), 16'(S_RING));
    do_tick();
    chk("tick2_buzzer", 16'(buzzer), 16'd1);
    do_tick();
    chk("autooff_state", 16'(state), 16'(S_ARMED));
    chk("autooff_ringing", 16'(ringing), 16'd0);
    chk("autooff_buzzer", 16'(buzzer), 16'd0);

    retrigger();
    chk("retrig_state", 16'(state), 16'(S_RING));
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    chk("snooze_state", 16'(state), 16'(S_SNZ));
    chk("snooze_buzzer", 16'(buzzer), 16'd0);
    do_tick();
    do_tick();
    do_tick();
    chk("snooze_tick3_state", 16'(state), 16'(S_SNZ));
    do_tick();
    chk("snooze_end_state", 16'(state), 16'(S_RING));
    chk("snooze_end_buzzer", 16'(buzzer), 16'd1);
    dismiss = 1'b1;
    cyc();
    dismiss = 1'b0;
    chk("dismiss_state", 16'(state), 16'(S_ARMED));
    cyc();
    cyc();
    cyc();
    chk("no_retrig_state", 16'(state), 16'(S_ARMED));
    chk("no_retrig_ringing", 16'(ringing), 16'd0);

    alarm_in = 8'h5A; set_alarm = 1'b1;
    cyc();
    set_alarm = 1'b0;
    chk("bad_set_err", 16'(set_err), 16'd1);
    chk("bad_set_alarm", 16'(alarm_bcd), 16'h0007);
    cyc();
    chk("bad_set_err_drop", 16'(set_err), 16'd0);

    retrigger();
    chk("both_pre_state", 16'(state), 16'(S_RING));
    snooze = 1'b1; dismiss = 1'b1;
    cyc();
    snooze = 1'b0; dismiss = 1'b0;
    chk("both_state", 16'(state), 16'(S_ARMED));

    retrigger();
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    do_tick();
    chk("armlow_pre_state", 16'(state), 16'(S_SNZ));
    arm = 1'b0;
    cyc();
    chk("armlow_state", 16'(state), 16'(S_IDLE));
    chk("armlow_buzzer", 16'(buzzer), 16'd0);
    arm = 1'b1;
    cyc();
    chk("rearm_state", 16'(state), 16'(S_ARMED));
    cyc();
    cyc();
    chk("rearm_no_ring", 16'(ringing), 16'd0);
    chk("rearm_hold_state", 16'(state), 16'(S_ARMED));

    retrigger();
    chk("rst_ring_pre", 16'(state), 16'(S_RING));
    reset = 1'b1;
    cyc();
    chk("rst2_state", 16'(state), 16'(S_IDLE));
    chk("rst2_ringing", 16'(ringing), 16'd0);
    chk("rst2_buzzer", 16'(buzzer), 16'd0);
    chk("rst2_set_err", 16'(set_err), 16'd0);
    chk("rst2_alarm", 16'(alarm_bcd), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
